aes128_round_datapath: RTL

//  Encrypt-side AES-128 datapath driven by the AES-128 control unit FSM. Accepts a

---
 rtl/aes128_pkg.sv | 20 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes128_round_datapath.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round-type codes, datapath FSM encoding and GF(2^8) doubling.
package aes128_pkg;

  localparam int AES_NR = 10;

  localparam logic [1:0] ROUND_INIT = 2'b00;
  localparam logic [1:0] ROUND_MID  = 2'b01;
  localparam logic [1:0] ROUND_LAST = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; table row r holds entries 16r..16r+15, entry 0 in the MSBs.
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base    = 11'd2047 - {byte_val, 3'b000};
  assign sub_val = SBOX_TABLE[base -: 8];

endmodule

// File: rtl/aes128_round_datapath.sv
// Encrypt-side AES-128 round datapath: one round per cycle under control-unit sequencing,
// with a valid/ready plaintext intake and a single-entry ciphertext output buffer.
module aes128_round_datapath
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         cu_start,
  output logic [127:0] cu_cipherkey,
  input  logic [1:0]   cu_round,
  input  logic         cu_done,
  input  logic [127:0] cu_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         err
);

  localparam int RW = $clog2(NUM_ROUNDS + 2);
  localparam logic [RW-1:0] RCNT_LAST = RW'(NUM_ROUNDS);

  fsm_t          fsm_reg;
  logic [127:0]  state_reg;
  logic [127:0]  cipherkey_reg;
  logic [127:0]  out_text_reg;
  logic          out_valid_reg;
  logic          err_reg;
  logic [RW-1:0] rcnt_reg;

  logic [127:0]  sub_state;
  logic [127:0]  round_mid_val;
  logic [127:0]  round_last_val;

  // Bytes are column-major: byte 4c+r sits at row r, column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .byte_val (state_reg[127-8*gi -: 8]),
        .sub_val  (sub_state[127-8*gi -: 8])
      );
    end
  endgenerate

  assign round_mid_val  = mix_columns(shift_rows(sub_state)) ^ cu_key;
  assign round_last_val = shift_rows(sub_state) ^ cu_key;

  assign in_ready     = (fsm_reg == IDLE) && (!out_valid_reg || out_ready);
  assign cu_start     = in_valid && in_ready;
  assign cu_cipherkey = cipherkey_reg;
  assign out_valid    = out_valid_reg;
  assign out_text     = out_text_reg;
  assign err          = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      cipherkey_reg <= '0;
      out_text_reg  <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      rcnt_reg      <= '0;
    end else begin
      // A load later in this block overrides the drain.
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (cu_done) err_reg <= 1'b1;
          if (cu_start) begin
            state_reg     <= in_text;
            cipherkey_reg <= in_key;
            rcnt_reg      <= '0;
            fsm_reg       <= RUN;
          end
        end
        RUN: begin
          rcnt_reg <= rcnt_reg + 1'b1;
          if (cu_done) begin
            fsm_reg <= DRAIN;
            if (rcnt_reg == RCNT_LAST) begin
              out_text_reg  <= round_last_val;
              out_valid_reg <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end else if (rcnt_reg == RCNT_LAST) begin
            // The count would pass the last round without done: abandon the block.
            err_reg <= 1'b1;
            fsm_reg <= DRAIN;
          end else begin
            case (cu_round)
              ROUND_INIT: state_reg <= state_reg ^ cu_key;
              ROUND_MID:  state_reg <= round_mid_val;
              ROUND_LAST: ;
              default: begin
                state_reg <= round_mid_val;
                err_reg   <= 1'b1;
              end
            endcase
          end
        end
        DRAIN: begin
          if (cu_done) err_reg <= 1'b1;
          fsm_reg <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule
